// File: rtl/vga_vram_arbiter_if.sv
// Request/grant/response bundle between the VRAM arbiter, its two requesters
// (VGA fetcher and CPU data bus) and the single-port video RAM.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  // video fetcher port
  logic                  vid_blank_i;
  logic                  vid_req_i;
  logic [ADDR_W-1:0]     vid_addr_i;
  logic                  vid_gnt_o;
  logic                  vid_rvalid_o;
  logic [DATA_W-1:0]     vid_rdata_o;
  // CPU port
  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [DATA_W/8-1:0]   cpu_be_i;
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [DATA_W-1:0]     cpu_wdata_i;
  logic                  cpu_gnt_o;
  logic                  cpu_rvalid_o;
  logic [DATA_W-1:0]     cpu_rdata_o;
  // RAM port
  logic                  mem_en_o;
  logic [DATA_W/8-1:0]   mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W-1:0]     mem_rdata_i;
  // stall statistics
  logic                  stall_clr_i;
  logic [15:0]           vid_stall_cnt_o;

  // arbiter side
  modport slave (
    input  vid_blank_i, vid_req_i, vid_addr_i,
    output vid_gnt_o, vid_rvalid_o, vid_rdata_o,
    input  cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    input  stall_clr_i,
    output vid_stall_cnt_o
  );

  // requester / environment side
  modport master (
    output vid_blank_i, vid_req_i, vid_addr_i,
    input  vid_gnt_o, vid_rvalid_o, vid_rdata_o,
    output cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    output stall_clr_i,
    input  vid_stall_cnt_o
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous VRAM between the VGA fetcher and the
// CPU. Video wins during active display, CPU wins during blanking, and a
// starvation counter forces a single CPU slot when it has waited too long.
module vga_vram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                rst_n,
  vga_vram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {VID_PRIO, CPU_PRIO, CPU_FORCE} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic                rdy_q;
  logic [7:0]          starve_q, starve_d;
  logic                vid_gnt, cpu_gnt;
  logic                own_vid_p1, own_cpu_p1, own_cpu_we_p1;
  logic [15:0]         stall_q;
  logic                mem_en;
  logic [DATA_W/8-1:0] mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Arbitration state, grant-enable flop and CPU starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= VID_PRIO;
      rdy_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      starve_q <= starve_d;
    end
  end

  // Grant selection and next state; the counter is checked on its next value
  // so the forced slot lands on request cycle STARVE_LIMIT+1
  always_comb begin
    vid_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    starve_d = '0;
    state_d  = VID_PRIO;
    if (rdy_q) begin
      case (state_q)
        VID_PRIO: begin
          vid_gnt = bus.vid_req_i;
          cpu_gnt = bus.cpu_req_i & ~bus.vid_req_i;
        end
        CPU_PRIO: begin
          cpu_gnt = bus.cpu_req_i;
          vid_gnt = bus.vid_req_i & ~bus.cpu_req_i;
        end
        default: cpu_gnt = bus.cpu_req_i;
      endcase
    end
    if (bus.cpu_req_i && !cpu_gnt) starve_d = starve_q + 8'd1;
    if (starve_d == LIMIT)         state_d = CPU_FORCE;
    else if (bus.vid_blank_i)      state_d = CPU_PRIO;
    else                           state_d = VID_PRIO;
  end

  // RAM command from the single winner; everything zero when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vid_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.vid_addr_i;
    end else if (cpu_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.cpu_addr_i;
      if (bus.cpu_we_i) begin
        mem_we    = bus.cpu_be_i;
        mem_wdata = bus.cpu_wdata_i;
      end
    end
  end

  // Owner of the access in flight, steering the next-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_vid_p1    <= 1'b0;
      own_cpu_p1    <= 1'b0;
      own_cpu_we_p1 <= 1'b0;
    end else begin
      own_vid_p1    <= vid_gnt;
      own_cpu_p1    <= cpu_gnt;
      own_cpu_we_p1 <= cpu_gnt & bus.cpu_we_i;
    end
  end

  // Saturating count of denied video cycles; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_q <= '0;
    else if (bus.stall_clr_i)            stall_q <= '0;
    else if (bus.vid_req_i && !vid_gnt)  stall_q <= sat_inc16(stall_q);
  end

  assign bus.vid_gnt_o       = vid_gnt;
  assign bus.cpu_gnt_o       = cpu_gnt;
  assign bus.mem_en_o        = mem_en;
  assign bus.mem_we_o        = mem_we;
  assign bus.mem_addr_o      = mem_addr;
  assign bus.mem_wdata_o     = mem_wdata;
  assign bus.vid_rvalid_o    = own_vid_p1;
  assign bus.vid_rdata_o     = own_vid_p1 ? bus.mem_rdata_i : '0;
  assign bus.cpu_rvalid_o    = own_cpu_p1;
  assign bus.cpu_rdata_o     = (own_cpu_p1 && !own_cpu_we_p1) ? bus.mem_rdata_i : '0;
  assign bus.vid_stall_cnt_o = stall_q;

endmodule
